ramio: RTL and testbench

RAMIO -- requirements
Module: ramio

---
 rtl/ramio_pkg.sv | 28 ++
 rtl/ramio_extract.sv | 17 +
 rtl/ramio.sv | 116 +++++++++++
 tb/tb_ramio.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ramio_pkg.sv
// ramio_pkg: request encodings, FSM states, lane masks and alignment helpers shared by ramio.
package ramio_pkg;
  typedef enum logic [2:0] {
    RD_NONE = 3'b000,
    RD_LB   = 3'b001,
    RD_LH   = 3'b010,
    RD_LW   = 3'b011,
    RD_LBU  = 3'b101,
    RD_LHU  = 3'b110
  } read_t;
  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_SB   = 2'b01,
    WR_SH   = 2'b10,
    WR_SW   = 2'b11
  } write_t;
  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2} state_t;
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;
  // size code: 1 byte, 2 half, 3 word
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    return sz == 2'd1 ? MASK_B : sz == 2'd2 ? MASK_H : MASK_W;
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
    return (sz == 2'd2 && lane == 2'd3) || (sz == 2'd3 && lane != 2'd0);
  endfunction
endpackage

// File: rtl/ramio_extract.sv
// ramio_extract: selects the byte/half at a lane of a cache word and sign/zero extends it.
module ramio_extract
  import ramio_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  read_type,
  output logic [31:0] data
);
  logic [31:0] sh;
  assign sh = word >> {lane, 3'b000};
  assign data = read_type == RD_LB  ? {{24{sh[7]}}, sh[7:0]}
              : read_type == RD_LBU ? {24'b0, sh[7:0]}
              : read_type == RD_LH  ? {{16{sh[15]}}, sh[15:0]}
              : read_type == RD_LHU ? {16'b0, sh[15:0]}
              : sh;
endmodule

// File: rtl/ramio.sv
// ramio: CPU byte-addressed load/store adapter onto a word-wide cache with lane shifting and extension.
// Define RAMIO_MISALIGNED_EN to split word-crossing accesses into two cache transactions instead of rejecting them.
module ramio
  import ramio_pkg::*;
#(
  parameter int AddressBitWidth = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [AddressBitWidth-1:0] address,
  input  logic [2:0]                 read_type,
  input  logic [1:0]                 write_type,
  input  logic [31:0]                data_in,
  output logic [31:0]                data_out,
  output logic                       data_out_ready,
  output logic                       busy,
  output logic                       alignment_error,
  output logic [AddressBitWidth-1:0] c_address,
  output logic [31:0]                c_data_in,
  output logic [3:0]                 c_write_enable,
  output logic                       c_enable,
  input  logic [31:0]                c_data_out,
  input  logic                       c_data_out_ready,
  input  logic                       c_busy
);
  state_t state, state_nx;
  logic [AddressBitWidth-1:0] req_addr;
  logic [2:0] req_rd;
  logic [1:0] req_sz, sz, lane, ext_lane;
  logic [31:0] req_data, ext_word, ext_data;
  logic req_is_wr, accept, mis, go, wait_done, finish, hi, split;
  logic [7:0] lane_mask;
  logic [63:0] lane_data;
  assign sz = write_type != 2'b00 ? write_type : read_type[1:0] == 2'b00 ? 2'd3 : read_type[1:0];
  assign lane = address[1:0];
  assign mis = misaligned(sz, lane);
  assign accept = enable && state == IDLE && (read_type != 3'b000 || write_type != 2'b00);
  assign hi = state == ISSUE2 || state == WAIT2;
  // Spread over two words: the low word feeds the first access, the high word the second.
  assign lane_mask = {4'b0000, size_mask(req_sz)} << req_addr[1:0];
  assign lane_data = {32'b0, req_data} << {req_addr[1:0], 3'b000};
  assign c_address = {req_addr[AddressBitWidth-1:2] + (AddressBitWidth-2)'(hi), 2'b00};
  assign c_data_in = hi ? lane_data[63:32] : lane_data[31:0];
  assign wait_done = (state == WAIT1 || state == WAIT2) && (req_is_wr ? !c_busy : c_data_out_ready);
  assign finish = wait_done && (state == WAIT2 || !split);
`ifdef RAMIO_MISALIGNED_EN
  logic [31:0] lo_word;
  assign go = accept;
  assign alignment_error = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      split <= 1'b0;
      lo_word <= '0;
    end else begin
      if (go) split <= mis;
      if (state == WAIT1 && c_data_out_ready) lo_word <= c_data_out;
    end
  // Little-endian merge of both words, realigned so the access starts at lane 0.
  assign ext_word = split ? 32'({c_data_out, lo_word} >> {req_addr[1:0], 3'b000}) : c_data_out;
  assign ext_lane = split ? 2'd0 : req_addr[1:0];
`else
  assign go = accept && !mis;
  assign split = 1'b0;
  assign ext_word = c_data_out;
  assign ext_lane = req_addr[1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) alignment_error <= 1'b0;
    else alignment_error <= accept && mis;
`endif
  ramio_extract u_extract (
    .word     (ext_word),
    .lane     (ext_lane),
    .read_type(req_rd),
    .data     (ext_data)
  );
  always_comb begin
    state_nx = state;
    busy = state != IDLE;
    c_enable = state != IDLE;
    c_write_enable = !req_is_wr ? 4'b0000
                   : state == ISSUE1 ? lane_mask[3:0]
                   : state == ISSUE2 ? lane_mask[7:4]
                   : 4'b0000;
    case (state)
      IDLE:    if (go) state_nx = ISSUE1;
      ISSUE1:  if (!c_busy) state_nx = WAIT1;
      WAIT1:   if (wait_done) state_nx = split ? ISSUE2 : IDLE;
      ISSUE2:  if (!c_busy) state_nx = WAIT2;
      WAIT2:   if (wait_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      req_addr <= '0;
      req_rd <= 3'b000;
      req_sz <= 2'b00;
      req_is_wr <= 1'b0;
      req_data <= '0;
      data_out <= '0;
      data_out_ready <= 1'b0;
    end else begin
      state <= state_nx;
      data_out_ready <= finish && !req_is_wr;
      if (go) begin
        req_addr <= address;
        req_rd <= read_type;
        req_sz <= sz;
        req_is_wr <= write_type != 2'b00;
        req_data <= data_in;
      end
      if (finish && !req_is_wr) data_out <= ext_data;
    end
endmodule

// File: tb/tb_ramio.sv
// tb_ramio: directed and random load/store checks of ramio against a byte-array memory model.
module tb_ramio;
`ifdef RAMIO_MISALIGNED_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [31:0] address = '0, data_in = '0, data_out, c_address, c_data_in, c_data_out = '0;
  logic [2:0] read_type = 3'b000;
  logic [1:0] write_type = 2'b00;
  logic [3:0] c_write_enable;
  logic data_out_ready, busy, alignment_error, c_enable, c_data_out_ready, c_busy;
  int n_pass = 0, n_total = 0;
  int n_acc = 0, m_cnt = 0, force_lat = -1, req_n0 = 0;
  logic [31:0] last_dout;
  logic m_phase = 1'b0, m_rd = 1'b0, m_stall = 1'b0, m_init = 1'b0, stall_en = 1'b0;
  logic [31:0] cmem [64];
  logic [31:0] init_words [64];
  logic [7:0] ref_mem [256];
  logic [31:0] acc_addr [1024];
  logic [31:0] acc_din [1024];
  logic [3:0] acc_we [1024];
  logic [2:0] rd_codes [5] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110};

  ramio #(.AddressBitWidth(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .address(address),
    .read_type(read_type), .write_type(write_type), .data_in(data_in),
    .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy),
    .alignment_error(alignment_error), .c_address(c_address), .c_data_in(c_data_in),
    .c_write_enable(c_write_enable), .c_enable(c_enable), .c_data_out(c_data_out),
    .c_data_out_ready(c_data_out_ready), .c_busy(c_busy)
  );

  always #5 clk = ~clk;

  // Cache model: accepts a request when enabled and not busy, stays busy for a random latency,
  // then presents read data (reads) or drops busy (writes) for one cycle.
  assign c_busy = m_phase ? m_cnt != 0 : m_stall;
  assign c_data_out_ready = m_phase && m_cnt == 0 && m_rd;
  always @(posedge clk) begin
    if (!m_init) begin
      for (int w = 0; w < 64; w++) cmem[w] <= init_words[w];
      m_init <= 1'b1;
    end else if (!m_phase) begin
      if (c_enable && !c_busy) begin
        acc_addr[n_acc] <= c_address;
        acc_we[n_acc] <= c_write_enable;
        acc_din[n_acc] <= c_data_in;
        n_acc <= n_acc + 1;
        c_data_out <= cmem[c_address[7:2]];
        for (int i = 0; i < 4; i++)
          if (c_write_enable[i]) cmem[c_address[7:2]][8*i +: 8] <= c_data_in[8*i +: 8];
        m_rd <= c_write_enable == 4'b0000;
        m_cnt <= force_lat >= 0 ? force_lat : int'($urandom_range(0, 3));
        m_phase <= 1'b1;
        m_stall <= 1'b0;
      end else m_stall <= stall_en && $urandom_range(0, 3) == 0;
    end else if (m_cnt == 0) m_phase <= 1'b0;
    else m_cnt <= m_cnt - 1;
  end

  function automatic int code_size(input logic [1:0] c);
    return c == 2'd3 ? 4 : int'(c);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] rt, input int a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < code_size(rt[1:0]); i++) v[8*i +: 8] = ref_mem[a + i];
    if (rt == 3'b001) v = {{24{v[7]}}, v[7:0]};
    if (rt == 3'b010) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_req(input logic [2:0] rt, input logic [1:0] wt, input int a,
                        input logic [31:0] din, input string tag);
    int n, n0, rdy_n, aerr_n, cen_n;
    bit wr, mis, rej, done, fall_rdy;
    logic [31:0] exp_v, dout;
    wr = wt != 2'd0;
    n = code_size(wr ? wt : rt[1:0]);
    mis = (a % 4) + n > 4;
    rej = mis && !MIS_EN;
    exp_v = wr ? 32'd0 : ref_load(rt, a);
    if (wr && !rej) for (int i = 0; i < n; i++) ref_mem[a + i] = din[8*i +: 8];
    rdy_n = 0; aerr_n = 0; cen_n = 0; done = 1'b0; fall_rdy = 1'b0; dout = '0;
    @(negedge clk);
    n0 = n_acc;
    address = 32'(a); read_type = rt; write_type = wt; data_in = din; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (data_out_ready) begin
        rdy_n++;
        dout = data_out;
      end
      if (alignment_error) aerr_n++;
      if (c_enable) cen_n++;
      if (!busy) begin
        done = 1'b1;
        fall_rdy = data_out_ready;
      end else @(negedge clk);
    end
    @(negedge clk);
    if (data_out_ready) rdy_n++;
    if (alignment_error) aerr_n++;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " ready pulses"}, rdy_n, (wr || rej) ? 0 : 1);
    check({tag, " ready at busy fall"}, 32'(fall_rdy), 32'(!wr && !rej));
    check({tag, " align err pulses"}, aerr_n, 32'(rej));
    check({tag, " cache accesses"}, n_acc - n0, rej ? 0 : mis ? 2 : 1);
    if (!wr && !rej) check({tag, " data"}, dout, exp_v);
    if (rej) check({tag, " c_enable cycles"}, cen_n, 0);
    last_dout = dout;
    req_n0 = n0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    for (int w = 0; w < 64; w++) init_words[w] = $urandom;
    init_words[2] = 32'hAB4C3E6F;
    init_words[3] = 32'h9D8E2F17;
    init_words[4] = 32'hD5B8A9C4;
    for (int b = 0; b < 256; b++) ref_mem[b] = init_words[b / 4][8*(b % 4) +: 8];
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset data_out_ready", data_out_ready, 0);
    check("reset alignment_error", alignment_error, 0);
    check("reset c_enable", c_enable, 0);
    check("reset c_write_enable", c_write_enable, 0);
    check("reset data_out", data_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(3'b001, 2'b00, 17, 0, "LB@17");
    check("LB@17 const", last_dout, 32'hFFFFFFA9);
    do_req(3'b101, 2'b00, 17, 0, "LBU@17");
    check("LBU@17 const", last_dout, 32'h000000A9);
    do_req(3'b010, 2'b00, 18, 0, "LH@18");
    check("LH@18 const", last_dout, 32'hFFFFD5B8);
    do_req(3'b110, 2'b00, 18, 0, "LHU@18");
    check("LHU@18 const", last_dout, 32'h0000D5B8);
    do_req(3'b000, 2'b01, 9, 32'h000000AD, "SB@9");
    check("SB@9 c_address", acc_addr[req_n0], 32'd8);
    check("SB@9 c_write_enable", 32'(acc_we[req_n0]), 32'b0010);
    check("SB@9 c_data_in", acc_din[req_n0], 32'h0000AD00);
    do_req(3'b011, 2'b00, 8, 0, "LW@8");
    check("LW@8 const", last_dout, 32'hAB4CAD6F);
    do_req(3'b011, 2'b00, 14, 0, "LW@14");
    if (MIS_EN) begin
      check("LW@14 first addr", acc_addr[req_n0], 32'd12);
      check("LW@14 second addr", acc_addr[req_n0 + 1], 32'd16);
      check("LW@14 const", last_dout, 32'hA9C49D8E);
    end
    // Reset while a load waits on a slow cache response.
    force_lat = 3;
    @(negedge clk);
    address = 32'd16; read_type = 3'b011; write_type = 2'b00; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("midrst busy before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst busy async", busy, 0);
    check("midrst c_enable", c_enable, 0);
    @(negedge clk);
    check("midrst busy edge", busy, 0);
    check("midrst data_out", data_out, 0);
    rst_n = 1'b1;
    begin
      int rdy;
      rdy = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (data_out_ready || busy) rdy++;
      end
      check("midrst stray activity", rdy, 0);
    end
    force_lat = -1;
    do_req(3'b011, 2'b00, 16, 0, "LW@16 after reset");
    check("LW@16 const", last_dout, 32'hD5B8A9C4);
    stall_en = 1'b1;
    for (int k = 0; k < 80; k++) begin
      int a;
      logic [2:0] rt;
      logic [1:0] wt;
      a = int'($urandom_range(0, 247));
      if ($urandom_range(0, 1) == 1) begin
        wt = 2'($urandom_range(1, 3));
        rt = 3'b000;
      end else begin
        wt = 2'b00;
        rt = rd_codes[$urandom_range(0, 4)];
      end
      do_req(rt, wt, a, $urandom, "rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
